// File: rtl/indication_arbiter.sv
// Round-robin, message-atomic arbiter that merges NREQ indication requesters
// into one portal indication channel through a DEPTH-entry FIFO.
module indication_arbiter #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    req_pending,
  output logic [NREQ-1:0]    RDY_req,
  input  logic [NREQ-1:0]    EN_req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  input  logic               intr_enable,
  output logic               RDY_first,
  output logic [DW-1:0]      first,
  output logic               RDY_deq,
  input  logic               EN_deq,
  output logic               notEmpty,
  output logic               intr_status,
  output logic [31:0]        intr_channel
);

  localparam int IW = $clog2(NREQ);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = IW + 1 + DW;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state, state_next;
  logic [IW-1:0]   grant, grant_next;
  logic [IW-1:0]   last_grant, last_grant_next;
  logic [IW-1:0]   cand;
  logic            found;
  logic [EW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, empty, enq, deq;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign enq   = (state == LOCK) && !full && EN_req[grant];
  assign deq   = EN_deq && !empty;

  always_comb begin
    RDY_req = '0;
    if (state == LOCK && !full) RDY_req[grant] = 1'b1;
  end

  // Round-robin search starts just after the requester that finished last.
  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    found           = 1'b0;
    cand            = '0;
    case (state)
      IDLE: begin
        for (int k = 1; k <= NREQ; k++) begin
          cand = IW'((int'(last_grant) + k) % NREQ);
          if (!found && req_pending[cand]) begin
            found      = 1'b1;
            grant_next = cand;
          end
        end
        if (found) state_next = LOCK;
      end
      LOCK: begin
        if (enq && req_last[grant]) begin
          last_grant_next = grant;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IW'(NREQ - 1);
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the empty flag masks stale entries on the outputs.
  always_ff @(posedge CLK) begin
    if (enq) mem[wr_ptr] <= {grant, req_last[grant], req_data[int'(grant)*DW +: DW]};
  end

  assign notEmpty     = !empty;
  assign RDY_first    = !empty;
  assign RDY_deq      = !empty;
  assign first        = empty ? '0 : mem[rd_ptr][DW-1:0];
  assign intr_channel = empty ? '0 : 32'(mem[rd_ptr][EW-1 -: IW]);
  assign intr_status  = !empty && intr_enable;

endmodule

// File: tb/tb_indication_arbiter.sv
// Directed bench for indication_arbiter: a queue-based reference model checked
// every cycle, plus hand-computed literal expectations per scenario.
module tb_indication_arbiter;
  localparam int NREQ  = 4;
  localparam int DEPTH = 8;
  localparam int DW    = 32;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic [NREQ-1:0]    req_pending = '0;
  logic [NREQ-1:0]    EN_req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    req_last = '0;
  logic               intr_enable = 1'b0;
  logic               EN_deq = 1'b0;
  logic [NREQ-1:0]    RDY_req;
  logic               RDY_first, RDY_deq, notEmpty, intr_status;
  logic [DW-1:0]      first;
  logic [31:0]        intr_channel;

  indication_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .DW(DW)) dut (
    .CLK(CLK), .RST(RST), .req_pending(req_pending), .RDY_req(RDY_req),
    .EN_req(EN_req), .req_data(req_data), .req_last(req_last),
    .intr_enable(intr_enable), .RDY_first(RDY_first), .first(first),
    .RDY_deq(RDY_deq), .EN_deq(EN_deq), .notEmpty(notEmpty),
    .intr_status(intr_status), .intr_channel(intr_channel)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Model: owner of the channel (if any), queue of {channel, data} words.
  bit          m_busy  = 1'b0;
  int          m_owner = 0;
  int          m_lastg = NREQ - 1;
  logic [39:0] mq[$];
  logic [39:0] log_q[$];
  bit          auto_deq = 1'b0;
  bit          deq_pulse = 1'b0;

  function automatic logic [NREQ-1:0] exp_rdy();
    if (m_busy && mq.size() < DEPTH) return NREQ'(1) << m_owner;
    return '0;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  initial begin
    bit was_busy, enq, deq;
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
        m_busy = 1'b0; m_owner = 0; m_lastg = NREQ - 1;
        mq.delete();
      end else begin
        was_busy = m_busy;
        enq = m_busy && mq.size() < DEPTH && EN_req[m_owner];
        deq = EN_deq && mq.size() > 0;
        if (deq) begin
          log_q.push_back(mq[0]);
          void'(mq.pop_front());
        end
        if (enq) begin
          mq.push_back({8'(m_owner), req_data[m_owner*DW +: DW]});
          if (req_last[m_owner]) begin
            m_lastg = m_owner;
            m_busy  = 1'b0;
          end
        end
        if (!was_busy && |req_pending) begin
          for (int k = 1; k <= NREQ; k++) begin
            if (!m_busy && req_pending[(m_lastg + k) % NREQ]) begin
              m_owner = (m_lastg + k) % NREQ;
              m_busy  = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic compare_all();
    logic [39:0] h;
    bit ne;
    ne = mq.size() > 0;
    h  = '0;
    if (ne) h = mq[0];
    check_output("rdy_req", RDY_req, exp_rdy());
    check_output("not_empty", notEmpty, ne);
    check_output("rdy_first", RDY_first, ne);
    check_output("rdy_deq", RDY_deq, ne);
    check_output("first", first, h[31:0]);
    check_output("intr_channel", intr_channel, {24'b0, h[39:32]});
    check_output("intr_status", intr_status, ne && intr_enable);
  endtask

  initial forever begin
    @(negedge CLK);
    compare_all();
  end

  initial forever begin
    @(negedge CLK);
    #2;
    EN_deq = (auto_deq && mq.size() > 0) || deq_pulse;
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic send_word(input int r, input logic [31:0] d, input bit last, input bit drop_pend);
    int n;
    logic [NREQ-1:0] v;
    n = 0;
    v = exp_rdy();
    while (!v[r] && n < 200) begin
      tick();
      n++;
      v = exp_rdy();
    end
    if (n >= 200) bound_fail("wait_rdy");
    EN_req[r] = 1'b1;
    req_data[r*DW +: DW] = d;
    req_last[r] = last;
    if (last && drop_pend) req_pending[r] = 1'b0;
    tick();
    EN_req[r]   = 1'b0;
    req_last[r] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    auto_deq = 1'b1;
    while (mq.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) bound_fail("drain");
    auto_deq = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    log_q.delete();
  endtask

  task automatic check_log(input string name, input int i, input int ch, input logic [31:0] d);
    logic [39:0] e;
    e = '0;
    if (i < log_q.size()) e = log_q[i];
    check_output(name, e, {8'(ch), d});
  endtask

  initial begin
    int rr_order[5] = '{0, 1, 2, 3, 0};
    int atom_ch[6]  = '{2, 2, 2, 2, 1, 1};
    logic [31:0] atom_d[6] = '{32'h200, 32'h201, 32'h202, 32'h203, 32'h110, 32'h111};
    logic [NREQ-1:0] v;
    int r, n;

    intr_enable = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    check_output("reset_rdy_req", RDY_req, 0);
    check_output("reset_not_empty", notEmpty, 0);
    check_output("reset_first", first, 0);
    check_output("reset_intr_status", intr_status, 0);
    check_output("reset_intr_channel", intr_channel, 0);

    // Single requester, three-word message, one-cycle grant latency
    req_pending = 4'b0001;
    tick();
    check_output("grant_latency", RDY_req, 4'b0001);
    send_word(0, 32'hA0, 1'b0, 1'b1);
    check_output("head_a0", first, 32'hA0);
    check_output("head_a0_chan", intr_channel, 0);
    check_output("head_a0_intr", intr_status, 1);
    send_word(0, 32'hA1, 1'b0, 1'b1);
    send_word(0, 32'hA2, 1'b1, 1'b1);
    drain();
    check_output("msg_a_count", log_q.size(), 3);
    check_log("msg_a0", 0, 0, 32'hA0);
    check_log("msg_a2", 2, 0, 32'hA2);

    // Round robin with every requester pending
    do_reset();
    auto_deq = 1'b1;
    req_pending = 4'b1111;
    for (int m = 0; m < 5; m++) begin
      n = 0;
      v = exp_rdy();
      while (v == 0 && n < 200) begin
        tick();
        n++;
        v = exp_rdy();
      end
      if (n >= 200) bound_fail("rr_grant");
      r = 0;
      for (int i = NREQ - 1; i >= 0; i--) if (v[i]) r = i;
      if (m == 4) req_pending = '0;
      send_word(r, 32'h10 + r, 1'b1, 1'b0);
    end
    drain();
    check_output("rr_count", log_q.size(), 5);
    for (int i = 0; i < 5; i++) check_log("rr_order", i, rr_order[i], 32'h10 + rr_order[i]);

    // Atomicity: requester 1 waits while requester 2 stalls between words
    log_q.delete();
    auto_deq = 1'b1;
    req_pending = 4'b0100;
    tick();
    req_pending = 4'b0110;
    for (int w = 0; w < 4; w++) begin
      send_word(2, 32'h200 + w, w == 3, 1'b1);
      if (w == 1) begin
        EN_req[1] = 1'b1;
        req_data[1*DW +: DW] = 32'hBAD;
        tick();
        EN_req[1] = 1'b0;
        tick();
      end else if (w < 3) begin
        tick();
        tick();
      end
    end
    send_word(1, 32'h110, 1'b0, 1'b1);
    send_word(1, 32'h111, 1'b1, 1'b1);
    drain();
    check_output("atom_count", log_q.size(), 6);
    for (int i = 0; i < 6; i++) check_log("atom_order", i, atom_ch[i], atom_d[i]);

    // Full FIFO and backpressure
    log_q.delete();
    req_pending = 4'b0001;
    for (int w = 0; w < 8; w++) send_word(0, 32'h300 + w, 1'b0, 1'b1);
    check_output("full_model_size", mq.size(), 8);
    check_output("full_rdy_low", RDY_req, 0);
    tick();
    check_output("full_rdy_stays_low", RDY_req, 0);
    deq_pulse = 1'b1;
    #2;
    check_output("full_no_bypass", RDY_req, 0);
    tick();
    deq_pulse = 1'b0;
    check_output("rdy_after_deq", RDY_req, 4'b0001);
    check_output("after_deq_size", mq.size(), 7);
    EN_req[0] = 1'b1;
    req_data[0 +: DW] = 32'h308;
    deq_pulse = 1'b1;
    tick();
    EN_req[0] = 1'b0;
    deq_pulse = 1'b0;
    check_output("enq_deq_size", mq.size(), 7);
    check_output("enq_deq_rdy", RDY_req, 4'b0001);
    check_output("enq_deq_head", first, 32'h302);
    send_word(0, 32'h309, 1'b1, 1'b1);
    check_output("full_again_rdy", RDY_req, 0);
    drain();
    check_output("full_log_count", log_q.size(), 10);
    check_log("full_word8", 8, 0, 32'h308);
    check_log("full_word9", 9, 0, 32'h309);

    // Interrupt enable and ignored operations
    log_q.delete();
    intr_enable = 1'b0;
    req_pending = 4'b1000;
    send_word(3, 32'hC3, 1'b1, 1'b1);
    check_output("intr_off_status", intr_status, 0);
    check_output("intr_off_not_empty", notEmpty, 1);
    check_output("intr_off_chan", intr_channel, 3);
    intr_enable = 1'b1;
    #1;
    check_output("intr_on_status", intr_status, 1);
    EN_req[3] = 1'b1;
    req_last[3] = 1'b1;
    req_data[3*DW +: DW] = 32'hDEAD;
    tick();
    EN_req[3] = 1'b0;
    req_last[3] = 1'b0;
    check_output("illegal_enq_size", mq.size(), 1);
    check_output("illegal_enq_head", first, 32'hC3);
    drain();
    deq_pulse = 1'b1;
    tick();
    deq_pulse = 1'b0;
    check_output("empty_deq_not_empty", notEmpty, 0);
    req_pending = 4'b0010;
    send_word(1, 32'hD1, 1'b1, 1'b1);
    check_output("after_illegal_head", first, 32'hD1);
    check_output("after_illegal_chan", intr_channel, 1);
    drain();

    // Asynchronous reset in the middle of a message
    log_q.delete();
    req_pending = 4'b0100;
    send_word(2, 32'h400, 1'b0, 1'b1);
    send_word(2, 32'h401, 1'b0, 1'b1);
    EN_req[2] = 1'b1;
    req_data[2*DW +: DW] = 32'h402;
    #1;
    RST = 1'b1;
    #1;
    check_output("async_rst_rdy_req", RDY_req, 0);
    check_output("async_rst_not_empty", notEmpty, 0);
    check_output("async_rst_first", first, 0);
    check_output("async_rst_chan", intr_channel, 0);
    check_output("async_rst_intr", intr_status, 0);
    EN_req[2] = 1'b0;
    req_pending = '0;
    tick();
    tick();
    RST = 1'b0;
    log_q.delete();
    req_pending = 4'b0101;
    tick();
    check_output("post_rst_grant", RDY_req, 4'b0001);
    send_word(0, 32'h500, 1'b0, 1'b1);
    send_word(0, 32'h501, 1'b1, 1'b1);
    for (int w = 0; w < 4; w++) send_word(2, 32'h400 + w, w == 3, 1'b1);
    drain();
    check_output("post_rst_count", log_q.size(), 6);
    check_log("post_rst_w0", 0, 0, 32'h500);
    check_log("post_rst_w2", 2, 2, 32'h400);
    check_log("post_rst_w5", 5, 2, 32'h403);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    checks++;
    $display("[TB] FAIL global_timeout: simulation bound expired at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
